// File: rtl/mips_muldiv_if.sv
// Command/result bundle between the decode/register-file stage and the
// iterative multiply/divide unit.
interface mips_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, operand_a, operand_b, hi_we, lo_we, write_data,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, hi_we, lo_we, write_data,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit: one shift-add or restoring-divide step
// per clock, owning the architectural HI/LO registers.
module mips_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  mips_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   divisor_reg;
  logic [WIDTH-1:0]   a_raw_reg;
  logic               is_div_reg;
  logic               neg_reg;
  logic               neg_rem_reg;
  logic               b_zero_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               done_reg, dbz_reg;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Signed ops work on magnitudes; the sign is re-applied in FIX.
  assign a_mag = (bus.op[0] && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
  assign b_mag = (bus.op[0] && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;

  // acc holds {partial product, multiplier} for multiply and
  // {remainder, dividend/quotient} for divide.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + (acc_reg[0] ? {1'b0, divisor_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, divisor_reg};
  assign div_next  = div_trial[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_reg ? -acc_reg : acc_reg;
  assign quot_fix = neg_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem_fix  = neg_rem_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt_reg == CNT_W'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      acc_reg     <= '0;
      divisor_reg <= '0;
      a_raw_reg   <= '0;
      is_div_reg  <= 1'b0;
      neg_reg     <= 1'b0;
      neg_rem_reg <= 1'b0;
      b_zero_reg  <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      done_reg    <= 1'b0;
      dbz_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            acc_reg     <= {{WIDTH{1'b0}}, a_mag};
            divisor_reg <= b_mag;
            a_raw_reg   <= bus.operand_a;
            is_div_reg  <= bus.op[1];
            neg_reg     <= bus.op[0] & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
            neg_rem_reg <= bus.op[0] & bus.operand_a[WIDTH-1];
            b_zero_reg  <= (bus.operand_b == '0);
            cnt_reg     <= CNT_W'(WIDTH);
          end else begin
            // MTHI/MTLO only land when no operation is being launched.
            if (bus.hi_we) hi_reg <= bus.write_data;
            if (bus.lo_we) lo_reg <= bus.write_data;
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          acc_reg <= is_div_reg ? div_next : mul_next;
        end
        FIX: begin
          done_reg <= 1'b1;
          if (is_div_reg && b_zero_reg) begin
            hi_reg  <= a_raw_reg;
            lo_reg  <= '1;
            dbz_reg <= 1'b1;
          end else if (is_div_reg) begin
            hi_reg <= rem_fix;
            lo_reg <= quot_fix;
          end else begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.done        = done_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule
